// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: issue/write port and HI/LO/busy result bundle of the multiply/divide unit
//  master: E-stage issue side (drives start/op/operands and mthi/mtlo writes)
//  slave : mdu_hilo itself (drives busy, hi, lo)
interface mdu_hilo_if;
    logic        md_start;
    logic [1:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hilo_wdata;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    modport master (output md_start, md_op, md_a, md_b, hi_we, lo_we, hilo_wdata, input busy, hi, lo);
    modport slave (input md_start, md_op, md_a, md_b, hi_we, lo_we, hilo_wdata, output busy, hi, lo);
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle mult/multu/div/divu unit owning the HI/LO registers
//  clk, reset (async, active-high) plus bus (mdu_hilo_if.slave):
//  md_start/md_op/md_a/md_b issue, hi_we/lo_we/hilo_wdata mthi/mtlo, busy/hi/lo out
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic        clk,
    input logic        reset,
    mdu_hilo_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
    logic        pwe_q, pwe_d;
    logic        sgn, a_neg, b_neg;
    logic [63:0] prod;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, q_res, r_res;
    // Result is precomputed at issue; the counter only models latency.
    // Signed divide works on magnitudes so INT_MIN / -1 wraps to INT_MIN, remainder 0.
    always_comb begin
        sgn   = ~bus.md_op[0];
        a_neg = sgn & bus.md_a[31];
        b_neg = sgn & bus.md_b[31];
        prod  = {{32{a_neg}}, bus.md_a} * {{32{b_neg}}, bus.md_b};
        a_mag = a_neg ? -bus.md_a : bus.md_a;
        b_mag = b_neg ? -bus.md_b : bus.md_b;
        q_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
        r_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
        q_res = (a_neg ^ b_neg) ? -q_mag : q_mag;
        r_res = a_neg ? -r_mag : r_mag;
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        pwe_d   = pwe_q;
        if (state_q == IDLE) begin
            if (bus.md_start) begin
                state_d = RUN;
                cnt_d   = bus.md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                phi_d   = bus.md_op[1] ? r_res : prod[63:32];
                plo_d   = bus.md_op[1] ? q_res : prod[31:0];
                pwe_d   = ~(bus.md_op[1] && bus.md_b == '0);
            end else begin
                hi_d = bus.hi_we ? bus.hilo_wdata : hi_q;
                lo_d = bus.lo_we ? bus.hilo_wdata : lo_q;
            end
        end else begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = IDLE;
                hi_d    = pwe_q ? phi_q : hi_q;
                lo_d    = pwe_q ? plo_q : lo_q;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            pwe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            pwe_q   <= pwe_d;
        end
    end
    assign bus.busy = (state_q == RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed plus random checks of mdu_hilo against an arithmetic HI/LO model
module tb_mdu_hilo;
    logic clk = 1'b0;
    logic reset;
    int total = 0;
    int passed = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    always #5 clk = ~clk;
    mdu_hilo_if bus();
    mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.md_start = 1'b0;
        bus.md_op = 2'b00;
        bus.md_a = '0;
        bus.md_b = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.hilo_wdata = '0;
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint unsigned ua = {32'h0, a};
        longint unsigned ub = {32'h0, b};
        longint unsigned p;
        case (op)
            2'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            2'd1: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
            2'd2: if (b != 0) begin p = sa / sb; m_lo = p[31:0]; p = sa % sb; m_hi = p[31:0]; end
            default: if (b != 0) begin p = ua / ub; m_lo = p[31:0]; p = ua % ub; m_hi = p[31:0]; end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit disturb);
        int n = op[1] ? 10 : 5;
        logic [31:0] oh = m_hi;
        logic [31:0] ol = m_lo;
        bus.md_start = 1'b1;
        bus.md_op = op;
        bus.md_a = a;
        bus.md_b = b;
        step();
        clear_inputs();
        model(op, a, b);
        for (int k = 0; k < n; k++) begin
            chk("busy_run", {31'b0, bus.busy}, 32'd1);
            chk("hi_hold", bus.hi, oh);
            chk("lo_hold", bus.lo, ol);
            if (disturb && k == 1) begin
                bus.md_start = 1'b1;
                bus.md_op = ~op;
                bus.md_a = $urandom;
                bus.md_b = $urandom;
                bus.hi_we = 1'b1;
                bus.lo_we = 1'b1;
                bus.hilo_wdata = 32'h55;
            end
            step();
            clear_inputs();
        end
        chk("busy_done", {31'b0, bus.busy}, 32'd0);
        chk("hi_result", bus.hi, m_hi);
        chk("lo_result", bus.lo, m_lo);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        step();
        run_op(2'd0, 32'hFFFFFFFF, 32'd2, 1'b0);
        chk("mult_hi_const", bus.hi, 32'hFFFFFFFF);
        chk("mult_lo_const", bus.lo, 32'hFFFFFFFE);
        run_op(2'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
        chk("multu_hi_const", bus.hi, 32'h00000001);
        run_op(2'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        chk("div_lo_const", bus.lo, 32'hFFFFFFFD);
        chk("div_hi_const", bus.hi, 32'hFFFFFFFF);
        run_op(2'd3, 32'd7, 32'd2, 1'b0);
        chk("divu_lo_const", bus.lo, 32'd3);
        chk("divu_hi_const", bus.hi, 32'd1);
        bus.hi_we = 1'b1;
        bus.hilo_wdata = 32'h1234;
        step();
        clear_inputs();
        m_hi = 32'h1234;
        chk("mthi", bus.hi, 32'h1234);
        chk("mthi_lo_kept", bus.lo, m_lo);
        run_op(2'd0, 32'd6, 32'hFFFFFFF9, 1'b1);
        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("ovf_lo", bus.lo, 32'h80000000);
        chk("ovf_hi", bus.hi, 32'h0);
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.hilo_wdata = 32'hA;
        step();
        bus.lo_we = 1'b1;
        bus.hi_we = 1'b0;
        bus.hilo_wdata = 32'hB;
        step();
        clear_inputs();
        m_hi = 32'hA;
        m_lo = 32'hB;
        chk("mt_both_hi", bus.hi, 32'hA);
        chk("mt_lo", bus.lo, 32'hB);
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.hilo_wdata = 32'hDEAD;
        run_op(2'd2, 32'd100, 32'd0, 1'b0);
        chk("div0_hi", bus.hi, 32'hA);
        chk("div0_lo", bus.lo, 32'hB);
        run_op(2'd3, 32'd100, 32'd0, 1'b1);
        bus.md_start = 1'b1;
        bus.md_op = 2'd0;
        bus.md_a = 32'd3;
        bus.md_b = 32'd4;
        step();
        clear_inputs();
        step();
        step();
        #3 reset = 1'b1;
        #1;
        chk("arst_busy", {31'b0, bus.busy}, 32'd0);
        chk("arst_hi", bus.hi, 32'h0);
        chk("arst_lo", bus.lo, 32'h0);
        m_hi = '0;
        m_lo = '0;
        step();
        reset = 1'b0;
        step();
        chk("post_rst_lo", bus.lo, 32'h0);
        run_op(2'd0, 32'd3, 32'd4, 1'b0);
        chk("post_rst_mult", bus.lo, 32'd12);
        for (int i = 0; i < 24; i++) begin
            logic [1:0] op = 2'($urandom_range(0, 3));
            logic [31:0] a = $urandom;
            logic [31:0] b = ($urandom_range(0, 7) == 0) ? 32'h0 : (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom);
            run_op(op, a, b, bit'($urandom_range(0, 1)));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
